// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter_if
// Brief    : Request and response bundle between issuing units and the shared
//            ALU arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]   req_valid_i;
    logic [NUM_REQ-1:0]   req_ready_o;
    logic [NUM_REQ*8-1:0] req_a_i;
    logic [NUM_REQ*8-1:0] req_b_i;
    logic [NUM_REQ*3-1:0] req_op_i;
    logic                 res_valid_o;
    logic                 res_ready_i;
    logic [7:0]           res_data_o;
    logic [ID_W-1:0]      res_id_o;
    logic                 busy_o;

    modport slave (
        input  req_valid_i, req_a_i, req_b_i, req_op_i, res_ready_i,
        output req_ready_o, res_valid_o, res_data_o, res_id_o, busy_o
    );

    modport master (
        output req_valid_i, req_a_i, req_b_i, req_op_i, res_ready_i,
        input  req_ready_o, res_valid_o, res_data_o, res_id_o, busy_o
    );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Brief    : Round-robin sharing of one 8-bit ALU between NUM_REQ requesters,
//            one operation in flight, result returned with the owner's ID.
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  wire logic      clk,
    input  wire logic      reset,
    alu_arbiter_if.slave   bus
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int IW1  = ID_W + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]      state_q,     state_d;
    logic [ID_W-1:0] rr_ptr_q,    rr_ptr_d;
    logic [7:0]      a_q,         a_d;
    logic [7:0]      b_q,         b_d;
    logic [2:0]      op_q,        op_d;
    logic [ID_W-1:0] id_q,        id_d;
    logic [7:0]      res_data_q,  res_data_d;
    logic [ID_W-1:0] res_id_q,    res_id_d;
    logic            res_valid_q, res_valid_d;
    logic            busy_q,      busy_d;

    logic               w_any;
    logic [ID_W-1:0]    w_grant;
    logic [IW1-1:0]     w_idx;
    logic [NUM_REQ-1:0] w_ready;
    logic [7:0]         w_alu;

    // Rotating priority search: first valid requester at or after rr_ptr wins.
    always_comb begin
        w_any   = 1'b0;
        w_grant = '0;
        w_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = {1'b0, rr_ptr_q} + IW1'(i);
            if (w_idx >= IW1'(NUM_REQ)) begin
                w_idx = w_idx - IW1'(NUM_REQ);
            end
            if (!w_any && bus.req_valid_i[w_idx[ID_W-1:0]]) begin
                w_any   = 1'b1;
                w_grant = w_idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        w_ready = '0;
        if (state_q == S_IDLE && w_any && !reset) begin
            w_ready[w_grant] = 1'b1;
        end
    end

    // ALU works only on the operands captured at accept time.
    always_comb begin
        w_alu = '0;
        case (op_q)
            3'b000:  w_alu = a_q + b_q;
            3'b001:  w_alu = a_q - b_q;
            3'b010:  w_alu = a_q << b_q[2:0];
            3'b011:  w_alu = a_q >> b_q[2:0];
            3'b100:  w_alu = a_q & b_q;
            3'b101:  w_alu = a_q | b_q;
            3'b110:  w_alu = a_q ^ b_q;
            default: w_alu = {7'b0, (a_q == b_q)};
        endcase
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        id_d        = id_q;
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;
        res_valid_d = res_valid_q;
        case (state_q)
            S_IDLE: begin
                if (w_any) begin
                    state_d  = S_EXEC;
                    a_d      = bus.req_a_i[8*w_grant +: 8];
                    b_d      = bus.req_b_i[8*w_grant +: 8];
                    op_d     = bus.req_op_i[3*w_grant +: 3];
                    id_d     = w_grant;
                    rr_ptr_d = (w_grant == ID_W'(NUM_REQ - 1)) ? '0 : w_grant + ID_W'(1);
                end
            end
            S_EXEC: begin
                state_d     = S_RESP;
                res_data_d  = w_alu;
                res_id_d    = id_q;
                res_valid_d = 1'b1;
            end
            S_RESP: begin
                if (bus.res_ready_i) begin
                    state_d     = S_IDLE;
                    res_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = S_IDLE;
                res_valid_d = 1'b0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            id_q        <= '0;
            res_data_q  <= '0;
            res_id_q    <= '0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            id_q        <= id_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.req_ready_o = w_ready;
    assign bus.res_valid_o = res_valid_q;
    assign bus.res_data_o  = res_data_q;
    assign bus.res_id_o    = res_id_q;
    assign bus.busy_o      = busy_q;

endmodule
`default_nettype wire
